// File: rtl/lane_mover.sv
// Frogger lane controller: steps N_OBJ obstacles along one lane with wrap,
// and reports whether a query X lands on any of them.
module lane_mover #(
    parameter int N_OBJ       = 3,
    parameter int X_W         = 10,
    parameter int SPAN        = 48,
    parameter int LEFT_BOUND  = 207,
    parameter int RIGHT_BOUND = 431,
    parameter int LANE_Y      = 222,
    parameter int STEP        = 1,
    parameter int CNT_W       = 22,
    parameter int SLOW_DIV    = 1000000,
    parameter int FAST_DIV    = 700000
) (
    input  logic                   frame_clk,
    input  logic                   Reset,
    input  logic [N_OBJ*X_W-1:0]   init_x,
    input  logic                   enable,
    input  logic                   dir,
    input  logic                   stage2x,
    input  logic [X_W-1:0]         query_x,
    output logic [N_OBJ*X_W-1:0]   obj_x,
    output logic [X_W-1:0]         obj_y,
    output logic                   moved,
    output logic                   on_obj,
    output logic [CNT_W-1:0]       counterx
);

    localparam logic [CNT_W-1:0] SLOW_T = CNT_W'(SLOW_DIV);
    localparam logic [CNT_W-1:0] FAST_T = CNT_W'(FAST_DIV);
    localparam logic [X_W:0]     L_SPAN = (X_W+1)'(SPAN);
    localparam logic [X_W:0]     L_STEP = (X_W+1)'(STEP);
    localparam logic [X_W:0]     L_LB   = (X_W+1)'(LEFT_BOUND);
    localparam logic [X_W:0]     L_RB   = (X_W+1)'(RIGHT_BOUND);
    localparam logic [X_W:0]     L_WRR  = (X_W+1)'(LEFT_BOUND - SPAN);

    logic [X_W-1:0]   r_x [N_OBJ];
    logic [CNT_W-1:0] r_cnt;
    logic             r_moved;
    logic             r_on;

    logic [CNT_W-1:0] w_term;
    logic             w_step;
    logic [X_W-1:0]   w_next [N_OBJ];
    logic [N_OBJ-1:0] w_hit;
    logic [X_W:0]     w_qe;

    assign w_term = stage2x ? FAST_T : SLOW_T;
    // >= so a slow-to-fast switch above FAST_DIV steps instead of wrapping
    assign w_step = enable && (r_cnt >= w_term);
    assign w_qe   = {1'b0, query_x};

    for (genvar g = 0; g < N_OBJ; g++) begin : g_obj
        logic [X_W:0] w_xe;
        logic [X_W:0] w_xs;
        logic [X_W:0] w_dec;
        logic [X_W:0] w_inc;

        assign w_xe  = {1'b0, r_x[g]};
        assign w_xs  = w_xe + L_SPAN;
        assign w_dec = w_xe - L_STEP;
        assign w_inc = w_xe + L_STEP;

        always_comb begin
            w_next[g] = r_x[g];
            if (dir) begin
                if (w_xe > L_RB) w_next[g] = L_WRR[X_W-1:0];
                else             w_next[g] = w_inc[X_W-1:0];
            end else begin
                if (w_xs < L_LB) w_next[g] = L_RB[X_W-1:0];
                else             w_next[g] = w_dec[X_W-1:0];
            end
        end

        assign w_hit[g] = (w_qe >= w_xe) && (w_qe < w_xs);
        assign obj_x[g*X_W +: X_W] = r_x[g];
    end

    always_ff @(posedge frame_clk) begin
        if (!Reset) begin
            for (int i = 0; i < N_OBJ; i++) r_x[i] <= init_x[i*X_W +: X_W];
            r_cnt   <= '0;
            r_moved <= 1'b0;
            r_on    <= 1'b0;
        end else begin
            r_on <= |w_hit;
            if (w_step) begin
                for (int i = 0; i < N_OBJ; i++) r_x[i] <= w_next[i];
                r_cnt   <= '0;
                r_moved <= 1'b1;
            end else begin
                if (enable) r_cnt <= r_cnt + 1'b1;
                r_moved <= 1'b0;
            end
        end
    end

    assign obj_y    = X_W'(LANE_Y);
    assign moved    = r_moved;
    assign on_obj   = r_on;
    assign counterx = r_cnt;

endmodule
